// File: rtl/otter_pkg.sv
// Shared types and constants for the OTTER fetch stage.
// Holds the fetch FSM states, the IF/ID bundle and the NOP word.
package otter_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_DROP
   } fetch_state_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] ir;
   } if_id_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction memory request/grant/response bus.
// master = fetch stage (REQ, ADDR out), slave = memory.
interface if_fetch_stage_if;

   logic        IMEM_REQ;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_GNT;
   logic        IMEM_RVALID;
   logic [31:0] IMEM_RDATA;

   modport master (
      output IMEM_REQ,
      output IMEM_ADDR,
      input  IMEM_GNT,
      input  IMEM_RVALID,
      input  IMEM_RDATA
   );

   modport slave (
      input  IMEM_REQ,
      input  IMEM_ADDR,
      output IMEM_GNT,
      output IMEM_RVALID,
      output IMEM_RDATA
   );

endinterface

// File: rtl/if_fetch_stage_hold_buf.sv
// if_hold_buf: one-entry skid buffer for a fetched instruction.
// Ports: clk, rst_n, clr, wr_en/wr_data, rd_en, valid/data.
module if_hold_buf
   import otter_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   clr,
   input  logic   wr_en,
   input  if_id_t wr_data,
   input  logic   rd_en,
   output logic   valid,
   output if_id_t data
);

   // A write in the same cycle as a read refills the entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (clr) begin
         valid <= 1'b0;
      end else if (wr_en) begin
         valid <= 1'b1;
         data  <= wr_data;
      end else if (rd_en) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC, imem fetch FSM and IF/ID register.
// Ports: CLK, RST_N, STALL, REDIRECT(_PC), imem bus, IF/ID outputs.
module if_fetch_stage #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR    = otter_pkg::NOP_INSTR
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    STALL,
   input  logic                    REDIRECT,
   input  logic [31:0]             REDIRECT_PC,
   if_fetch_stage_if.master        imem,
   output logic                    IF_ID_VALID,
   output logic [31:0]             IF_ID_PC,
   output logic [31:0]             IF_ID_PC4,
   output logic [31:0]             IF_ID_IR,
   output logic [6:0]              OPCODE,
   output logic [2:0]              FUNC3,
   output logic                    FUNC7
);

   import otter_pkg::*;

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  pend_pc;
   if_id_t       if_id;
   if_id_t       resp_ent;
   if_id_t       hold_data;
   logic         hold_valid;
   logic         hold_wr;
   logic         hold_rd;
   logic         resp;
   logic         unused_pc_lsb;

   assign unused_pc_lsb = ^REDIRECT_PC[1:0];

   assign resp     = (state == S_WAIT) && imem.IMEM_RVALID;
   assign resp_ent = '{valid: 1'b1,
                       pc:    pend_pc,
                       ir:    imem.IMEM_RDATA};

   // No new request while the skid entry is occupied.
   assign imem.IMEM_REQ  = (state == S_FETCH) && !hold_valid;
   assign imem.IMEM_ADDR = pc;

   always_comb begin
      hold_wr = 1'b0;
      hold_rd = 1'b0;
      if (!REDIRECT) begin
         if (!STALL) begin
            hold_rd = hold_valid;
            hold_wr = resp && hold_valid;
         end else begin
            hold_wr = resp && if_id.valid;
         end
      end
   end

   if_hold_buf u_hold (
      .clk     (CLK),
      .rst_n   (RST_N),
      .clr     (REDIRECT),
      .wr_en   (hold_wr),
      .wr_data (resp_ent),
      .rd_en   (hold_rd),
      .valid   (hold_valid),
      .data    (hold_data)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= S_IDLE;
         pc      <= RESET_VECTOR;
         pend_pc <= '0;
         if_id   <= '{valid: 1'b0,
                      pc:    32'h0,
                      ir:    NOP_INSTR};
      end else begin
         unique case (state)
            S_IDLE: state <= S_FETCH;
            S_FETCH: begin
               if (imem.IMEM_REQ && imem.IMEM_GNT) begin
                  pend_pc <= pc;
                  pc      <= pc + 32'd4;
                  state   <= REDIRECT ? S_DROP : S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem.IMEM_RVALID) state <= S_FETCH;
               else if (REDIRECT)    state <= S_DROP;
            end
            S_DROP: begin
               if (imem.IMEM_RVALID) state <= S_FETCH;
            end
            default: state <= S_IDLE;
         endcase

         // Redirect overrides the sequential PC update above.
         if (REDIRECT) begin
            pc          <= {REDIRECT_PC[31:2], 2'b00};
            if_id.valid <= 1'b0;
            if_id.ir    <= NOP_INSTR;
         end else if (!STALL) begin
            if (hold_valid) begin
               if_id <= hold_data;
            end else if (resp) begin
               if_id <= resp_ent;
            end else begin
               if_id.valid <= 1'b0;
               if_id.ir    <= NOP_INSTR;
            end
         end else if (!if_id.valid && resp) begin
            if_id <= resp_ent;
         end
      end
   end

   assign IF_ID_VALID = if_id.valid;
   assign IF_ID_PC    = if_id.pc;
   assign IF_ID_PC4   = if_id.pc + 32'd4;
   assign IF_ID_IR    = if_id.ir;
   assign OPCODE      = if_id.ir[6:0];
   assign FUNC3       = if_id.ir[14:12];
   assign FUNC7       = if_id.ir[30];

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the pipelined OTTER core.
- Owns the PC and issues word fetches to instruction memory over a request/grant/response handshake.
- Registers fetched instructions into IF/ID and drives OPCODE/FUNC3/FUNC7 straight into the decode control unit.
- Handles stall from the hazard unit and redirect (flush) from the branch/jump resolution in EX.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID on bubble/flush (addi x0,x0,0)

Ports:
CLK  in  1  core clock, rising edge
RST_N  in  1  reset, asynchronous, active-low
STALL  in  1  hazard unit: hold IF/ID contents
REDIRECT  in  1  EX: taken branch/jump, flush IF/ID
REDIRECT_PC  in  32  new fetch address
IMEM_REQ  out  1  fetch request
IMEM_ADDR  out  32  fetch address, word aligned
IMEM_GNT  in  1  request accepted this cycle
IMEM_RVALID  in  1  response data valid
IMEM_RDATA  in  32  fetched instruction
IF_ID_VALID  out  1  IF/ID holds a real instruction
IF_ID_PC  out  32  PC of IF/ID instruction
IF_ID_PC4  out  32  IF_ID_PC + 4
IF_ID_IR  out  32  instruction word
OPCODE  out  7  IF_ID_IR[6:0]
FUNC3  out  3  IF_ID_IR[14:12]
FUNC7  out  1  IF_ID_IR[30]

Behaviour:
- Reset (RST_N low, asynchronous):
  - PC=RESET_VECTOR, state=S_IDLE, hold buffer empty.
  - IF_ID_VALID=0, IF_ID_IR=NOP_INSTR, IF_ID_PC=0, IF_ID_PC4=4.
  - IMEM_REQ=0, IMEM_ADDR=PC.
- Handshake:
  - At most one request outstanding.
  - IMEM_REQ and IMEM_ADDR are held stable until IMEM_GNT.
  - Response arrives ≥1 cycle after the grant cycle, exactly once per grant.
- States:
  - S_IDLE: first cycle after reset release → S_FETCH.
  - S_FETCH:
    - IMEM_REQ = !hold_valid; IMEM_ADDR = PC.
    - On GNT: pend_pc<=PC, PC<=PC+4 (mod 2^32; FFFF_FFFC wraps to 0000_0000) → S_WAIT.
  - S_WAIT: on RVALID, deliver {pend_pc, RDATA} (see below) → S_FETCH.
  - S_DROP: stale request outstanding; IMEM_REQ=0; on RVALID discard data → S_FETCH.
- Delivery of a response or buffered entry:
  - STALL=0: IF/ID <= hold entry if hold_valid (hold cleared; a same-cycle response goes to hold), else the response, else a bubble (VALID=0, IR=NOP_INSTR).
  - STALL=1 and IF_ID_VALID=1: IF/ID unchanged; a response is written to the hold buffer (never occurs while hold full, since REQ is gated).
  - STALL=1 and IF_ID_VALID=0: the response loads IF/ID directly.
- REDIRECT (priority over STALL and everything else):
  - PC <= {REDIRECT_PC[31:2],2'b00}.
  - IF_ID_VALID<=0, IF_ID_IR<=NOP_INSTR, hold cleared.
  - S_FETCH with GNT same cycle → S_DROP.
  - S_WAIT without RVALID → S_DROP.
  - S_WAIT with RVALID → data discarded, S_FETCH.
  - S_DROP → stays S_DROP (PC updated).
  - S_FETCH without GNT → stays S_FETCH; the address switches next cycle.
- Latency: grant to IF/ID update is response latency + 1 edge (IF/ID register).
- OPCODE/FUNC3/FUNC7/IF_ID_PC4 are combinational slices/adders of the IF/ID registers.
- Reset asserted mid-S_WAIT: the outstanding response is ignored; memory is reset by the same RST_N.

Decomposition:
- otter_pkg:
  - NOP_INSTR constant.
  - fetch_state_t enum {S_IDLE,S_FETCH,S_WAIT,S_DROP}.
  - if_id_t struct {valid,pc,ir}.
- One sub-module: if_hold_buf. One-entry skid buffer with write, read and clear; async active-low reset.

Test Plan:
- Reset, then zero-wait memory (GNT=1, RVALID next cycle) → IMEM_ADDR 0,4,8,…; IF_ID_IR follows RDATA; IF_ID_PC 0,4,8; OPCODE=IR[6:0].
- STALL=1 while IF/ID holds PC 4 and the response for PC 8 arrives:
  - IF/ID stays PC 4; IMEM_REQ=0.
  - STALL drops → IF/ID=PC 8 next edge; fetch of 12 resumes.
- REDIRECT to 0x100 while S_WAIT for PC 0x10 (response 3 cycles later):
  - IF_ID_VALID=0, IR=0x00000013.
  - Stale 0x10 data never appears.
  - Next request address 0x100.
- REDIRECT to 0x203 in the same cycle as GNT → S_DROP; next request address 0x200; the granted response is dropped.
- PC=0xFFFFFFFC fetched → next IMEM_ADDR 0x00000000; IF_ID_PC4=0x00000000.
- RST_N pulsed low mid-S_WAIT → outputs take reset values immediately (asynchronous); fetch restarts at RESET_VECTOR two cycles after release.
